// File: rtl/qsys_timer_pkg.sv
// Shared register map, control/status bit positions and the per-channel
// write-strobe bundle for the multi-channel interval timer.
package qsys_timer_pkg;

    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD   = 3'd2;
    localparam logic [2:0] REG_COMPARE  = 3'd3;
    localparam logic [2:0] REG_SNAPSHOT = 3'd4;
    localparam logic [2:0] REG_PRESC    = 3'd5;

    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;
    localparam int CTRL_PWM   = 4;

    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

    // One strobe per writable register of a single channel.
    typedef struct packed {
        logic status;
        logic control;
        logic period;
        logic compare;
        logic snapshot;
        logic presc;
    } reg_wr_t;

endpackage

// File: rtl/qsys_timer_channel.sv
// One timer channel: prescaled down-counter with reload, one-shot/continuous
// run control, timeout flag, snapshot register and registered PWM compare.
module qsys_timer_channel
    import qsys_timer_pkg::*;
#(
    parameter int          COUNTER_W      = 32,
    parameter int          PRESC_W        = 16,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h1387F
) (
    input  logic        clk,
    input  logic        reset_n,
    input  reg_wr_t     wr,
    input  logic [31:0] writedata,
    output logic [31:0] status_val,
    output logic [31:0] control_val,
    output logic [31:0] period_val,
    output logic [31:0] compare_val,
    output logic [31:0] snapshot_val,
    output logic [31:0] presc_val,
    output logic        irq,
    output logic        pwm
);

    logic [COUNTER_W-1:0] counter;
    logic [COUNTER_W-1:0] period;
    logic [COUNTER_W-1:0] compare;
    logic [COUNTER_W-1:0] snapshot;
    logic [PRESC_W-1:0]   presc;
    logic [PRESC_W-1:0]   pcount;
    logic                 run;
    logic                 to;
    logic                 ito;
    logic                 cont;
    logic                 pwm_en;
    logic                 force_reload;
    logic                 start;
    logic                 stop;
    logic                 tick;
    logic                 expire;

    assign start  = wr.control & writedata[CTRL_START];
    assign stop   = wr.control & writedata[CTRL_STOP];
    assign tick   = run & (pcount == presc);
    // A reload forced by a PERIOD write overrides a coincident expiry: no TO.
    assign expire = tick & (counter == '0) & ~force_reload;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            counter      <= COUNTER_W'(DEFAULT_PERIOD);
            period       <= COUNTER_W'(DEFAULT_PERIOD);
            compare      <= '0;
            snapshot     <= '0;
            presc        <= '0;
            pcount       <= '0;
            run          <= 1'b0;
            to           <= 1'b0;
            ito          <= 1'b0;
            cont         <= 1'b0;
            pwm_en       <= 1'b0;
            force_reload <= 1'b0;
            pwm          <= 1'b0;
        end else begin
            force_reload <= wr.period;

            if (wr.period)   period   <= writedata[COUNTER_W-1:0];
            if (wr.compare)  compare  <= writedata[COUNTER_W-1:0];
            if (wr.presc)    presc    <= writedata[PRESC_W-1:0];
            if (wr.snapshot) snapshot <= counter;
            if (wr.control) begin
                ito    <= writedata[CTRL_ITO];
                cont   <= writedata[CTRL_CONT];
                pwm_en <= writedata[CTRL_PWM];
            end

            if (start || force_reload || tick) pcount <= '0;
            else if (run)                      pcount <= pcount + PRESC_W'(1);

            if (force_reload) counter <= period;
            else if (tick)    counter <= (counter == '0) ? period : counter - COUNTER_W'(1);

            if (start)                                       run <= 1'b1;
            else if (stop || force_reload || (expire && !cont)) run <= 1'b0;

            if (wr.status)   to <= 1'b0;
            else if (expire) to <= 1'b1;

            pwm <= run & pwm_en & (counter < compare);
        end
    end

    assign irq          = to & ito;
    assign status_val   = 32'({run, to});
    assign control_val  = 32'({pwm_en, 2'b00, cont, ito});
    assign period_val   = 32'(period);
    assign compare_val  = 32'(compare);
    assign snapshot_val = 32'(snapshot);
    assign presc_val    = 32'(presc);

endmodule

// File: rtl/qsys_multi_timer.sv
// Avalon-MM multi-channel interval timer: address decode into per-channel
// write strobes, registered read mux, and interrupt OR-reduction.
module qsys_multi_timer
    import qsys_timer_pkg::*;
#(
    parameter int          NUM_CH         = 4,
    parameter int          CH_AW          = 2,
    parameter int          COUNTER_W      = 32,
    parameter int          PRESC_W        = 16,
    parameter logic [31:0] DEFAULT_PERIOD = 32'h1387F
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [CH_AW+2:0]  address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec,
    output logic [NUM_CH-1:0] pwm_out
);

    // Every encodable channel slot gets a read entry; unpopulated ones read 0.
    localparam int SLOTS = 1 << CH_AW;

    logic [CH_AW-1:0] ch_sel;
    logic [2:0]       reg_sel;
    logic             wr_en;
    logic [31:0]      rd_val [SLOTS][8];

    assign ch_sel  = address[CH_AW+2:3];
    assign reg_sel = address[2:0];
    assign wr_en   = chipselect & ~write_n;

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        if (i < NUM_CH) begin : g_ch
            reg_wr_t ch_wr;

            // NOTE: defaulting every field first keeps this block free of latches.
            always_comb begin
                ch_wr = '0;
                if (wr_en && ch_sel == CH_AW'(i)) begin
                    case (reg_sel)
                        REG_STATUS:   ch_wr.status   = 1'b1;
                        REG_CONTROL:  ch_wr.control  = 1'b1;
                        REG_PERIOD:   ch_wr.period   = 1'b1;
                        REG_COMPARE:  ch_wr.compare  = 1'b1;
                        REG_SNAPSHOT: ch_wr.snapshot = 1'b1;
                        REG_PRESC:    ch_wr.presc    = 1'b1;
                        default:      ;
                    endcase
                end
            end

            qsys_timer_channel #(
                .COUNTER_W      (COUNTER_W),
                .PRESC_W        (PRESC_W),
                .DEFAULT_PERIOD (DEFAULT_PERIOD)
            ) u_ch (
                .clk          (clk),
                .reset_n      (reset_n),
                .wr           (ch_wr),
                .writedata    (writedata),
                .status_val   (rd_val[i][0]),
                .control_val  (rd_val[i][1]),
                .period_val   (rd_val[i][2]),
                .compare_val  (rd_val[i][3]),
                .snapshot_val (rd_val[i][4]),
                .presc_val    (rd_val[i][5]),
                .irq          (irq_vec[i]),
                .pwm          (pwm_out[i])
            );

            assign rd_val[i][6] = '0;
            assign rd_val[i][7] = '0;
        end else begin : g_empty
            for (genvar r = 0; r < 8; r++) begin : g_zero
                assign rd_val[i][r] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_val[ch_sel][reg_sel];
    end

    assign irq = |irq_vec;

endmodule

// File: tb/tb_qsys_multi_timer.sv
// Scoreboard bench for qsys_multi_timer: bus reads push expectations that a
// monitor retires one cycle later; timing is checked against closed-form intervals.
module tb_qsys_multi_timer;

    localparam int          NUM_CH     = 4;
    localparam int          CH_AW      = 3;
    localparam int          COUNTER_W  = 32;
    localparam int          PRESC_W    = 16;
    localparam logic [31:0] DEF_PERIOD = 32'h1387F;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [CH_AW+2:0]  address = '0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = '0;
    logic [31:0]       readdata;
    logic              irq;
    logic [NUM_CH-1:0] irq_vec;
    logic [NUM_CH-1:0] pwm_out;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int wr_cyc = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];
    logic        rd_flag = 1'b0;

    logic [31:0] m_ctrl    [NUM_CH];
    logic [31:0] m_period  [NUM_CH];
    logic [31:0] m_compare [NUM_CH];
    logic [31:0] m_snap    [NUM_CH];
    logic [31:0] m_presc   [NUM_CH];
    logic [31:0] m_cnt     [NUM_CH];

    qsys_multi_timer #(
        .NUM_CH         (NUM_CH),
        .CH_AW          (CH_AW),
        .COUNTER_W      (COUNTER_W),
        .PRESC_W        (PRESC_W),
        .DEFAULT_PERIOD (DEF_PERIOD)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .irq_vec    (irq_vec),
        .pwm_out    (pwm_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: a read presented before an edge is valid just after that edge.
    always @(posedge clk) begin
        if (rd_flag) begin
            #1;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_read: got 0x%08h expected none", readdata);
            end else begin
                check(name_q.pop_front(), readdata, exp_q.pop_front());
            end
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_ctrl[i]    = '0;
            m_period[i]  = DEF_PERIOD;
            m_compare[i] = '0;
            m_snap[i]    = '0;
            m_presc[i]   = '0;
            m_cnt[i]     = DEF_PERIOD;
        end
    endtask

    // Register-file view of an idle (never started) channel.
    task automatic model_write(int ch, int r, logic [31:0] d);
        if (ch < NUM_CH) begin
            case (r)
                1: m_ctrl[ch]    = d & 32'h13;
                2: begin m_period[ch] = d; m_cnt[ch] = d; end
                3: m_compare[ch] = d;
                4: m_snap[ch]    = m_cnt[ch];
                5: m_presc[ch]   = d & 32'h0000_FFFF;
                default: ;
            endcase
        end
    endtask

    function automatic logic [31:0] model_read(int ch, int r);
        if (ch >= NUM_CH) return '0;
        case (r)
            1:       return m_ctrl[ch];
            2:       return m_period[ch];
            3:       return m_compare[ch];
            4:       return m_snap[ch];
            5:       return m_presc[ch];
            default: return '0;
        endcase
    endfunction

    function automatic int pwm_expect(int cmp, int per, int window);
        int hi;
        hi = (cmp < per + 1) ? cmp : per + 1;
        return window * hi / (per + 1);
    endfunction

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_until(int c);
        while (cyc < c) begin @(posedge clk); #1; end
    endtask

    task automatic bus_write(int ch, int r, logic [31:0] d);
        address    = {CH_AW'(ch), 3'(r)};
        chipselect = 1'b1;
        write_n    = 1'b0;
        writedata  = d;
        @(posedge clk); #1;
        wr_cyc     = cyc;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic bus_read(int ch, int r, logic [31:0] e, string nm);
        address    = {CH_AW'(ch), 3'(r)};
        chipselect = 1'b1;
        write_n    = 1'b1;
        exp_q.push_back(e);
        name_q.push_back(nm);
        rd_flag    = 1'b1;
        @(posedge clk); #1;
        rd_flag    = 1'b0;
        chipselect = 1'b0;
    endtask

    task automatic wait_irq(int ch, int limit, output int seen);
        seen = 0;
        for (int k = 0; k < limit; k++) begin
            @(posedge clk); #1;
            if (irq_vec[ch]) begin
                seen = cyc;
                return;
            end
        end
    endtask

    task automatic count_pwm(int ch, int window, output int n);
        n = 0;
        for (int k = 0; k < window; k++) begin
            @(posedge clk); #1;
            if (pwm_out[ch]) n++;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int seen;
        int n;
        int ch;
        int r;
        logic [31:0] d;

        model_reset();
        reset_n = 1'b0;
        idle(3);
        check("rst_irq", 32'(irq), 0);
        check("rst_irq_vec", 32'(irq_vec), 0);
        check("rst_pwm", 32'(pwm_out), 0);
        check("rst_readdata", readdata, 0);
        reset_n = 1'b1;
        idle(1);

        for (int i = 0; i < 8; i++) bus_read(0, i, model_read(0, i), $sformatf("rst_ch0_r%0d", i));
        check("rst_irq_after", 32'(irq), 0);

        // Random register traffic on idle channels, including unpopulated slots.
        for (int k = 0; k < 80; k++) begin
            ch = $urandom_range(0, 7);
            r  = $urandom_range(0, 7);
            d  = $urandom();
            case ($urandom_range(0, 2))
                0: begin
                    if (r == 1) d[2] = 1'b0;
                    bus_write(ch, r, d);
                    model_write(ch, r, d);
                    idle(1);
                end
                1: bus_read(ch, r, model_read(ch, r), $sformatf("rnd_rd_ch%0d_r%0d", ch, r));
                default: begin
                    bus_write(ch, 4, d);
                    model_write(ch, 4, d);
                    bus_read(ch, 4, model_read(ch, 4), $sformatf("rnd_snap_ch%0d", ch));
                end
            endcase
        end

        bus_write(5, 2, 32'h1234);
        idle(1);
        bus_read(5, 2, 32'h0, "inv_ch_read");
        bus_read(1, 2, m_period[1], "inv_ch_no_alias");

        // Continuous timer, PERIOD=9, PRESC=0: timeout every 10 clocks.
        bus_write(1, 2, 9);
        bus_write(1, 5, 0);
        bus_write(1, 1, 32'h7);
        t0 = wr_cyc;
        wait_irq(1, 40, seen);
        check("t2_first_to", 32'(seen - t0), 32'((9 + 1) * (0 + 1)));
        check("t2_irq_or", 32'(irq), 1);
        bus_write(1, 0, 0);
        check("t2_clear_irq_vec", 32'(irq_vec[1]), 0);
        check("t2_clear_irq", 32'(irq), 0);
        wait_irq(1, 40, seen);
        check("t2_second_to", 32'(seen - t0), 20);
        bus_write(1, 0, 0);
        wait_until(t0 + 29);
        bus_write(1, 0, 0);
        check("t2_clear_vs_timeout", 32'(irq_vec[1]), 0);
        wait_irq(1, 40, seen);
        check("t2_fourth_to", 32'(seen - t0), 40);
        bus_write(1, 1, 32'h8);
        bus_write(1, 0, 0);
        check("t2_stopped_irq", 32'(irq), 0);

        // One-shot, PERIOD=3, PRESC=4: single timeout after 20 clocks.
        bus_write(2, 2, 3);
        bus_write(2, 5, 4);
        bus_write(2, 1, 32'h5);
        t0 = wr_cyc;
        wait_irq(2, 60, seen);
        check("t3_timeout", 32'(seen - t0), 32'((3 + 1) * (4 + 1)));
        bus_read(2, 0, 32'h1, "t3_status_run_off");
        bus_write(2, 4, 0);
        bus_read(2, 4, 32'd3, "t3_snapshot_reloaded");
        bus_write(2, 0, 0);
        idle(60);
        check("t3_no_retrigger", 32'(irq_vec[2]), 0);

        // PWM duty against COMPARE.
        bus_write(3, 5, 0);
        bus_write(3, 2, 99);
        bus_write(3, 3, 25);
        bus_write(3, 1, 32'h16);
        idle(5);
        count_pwm(3, 200, n);
        check("t4_pwm_25", 32'(n), 32'(pwm_expect(25, 99, 200)));
        bus_write(3, 3, 0);
        idle(3);
        count_pwm(3, 100, n);
        check("t4_pwm_cmp0", 32'(n), 32'(pwm_expect(0, 99, 100)));
        bus_write(3, 3, 200);
        idle(3);
        count_pwm(3, 100, n);
        check("t4_pwm_cmp200", 32'(n), 32'(pwm_expect(200, 99, 100)));
        bus_write(3, 1, 32'h8);
        idle(2);
        check("t4_pwm_stopped", 32'(pwm_out[3]), 0);

        // PERIOD write while running; START with STOP.
        bus_write(0, 5, 0);
        bus_write(0, 2, 4);
        bus_write(0, 1, 32'h6);
        idle(12);
        check("t5_ito_masked", 32'(irq_vec[0]), 0);
        bus_write(0, 2, 50);
        bus_read(0, 0, 32'h3, "t5_run_before_reload");
        bus_read(0, 0, 32'h1, "t5_run_cleared_to_kept");
        bus_write(0, 4, 0);
        bus_read(0, 4, 32'd50, "t5_counter_reloaded");
        idle(10);
        bus_write(0, 4, 0);
        bus_read(0, 4, 32'd50, "t5_counter_holds");
        bus_write(0, 1, 32'hC);
        bus_read(0, 0, 32'h3, "t5_start_beats_stop");
        bus_write(0, 1, 32'h8);
        bus_write(0, 0, 0);
        bus_read(0, 0, 32'h0, "t5_stopped");

        // Asynchronous reset in the middle of counting on every channel.
        for (int i = 0; i < NUM_CH; i++) begin
            bus_write(i, 5, 0);
            bus_write(i, 2, 32'(2 + i));
            bus_write(i, 3, 200);
            bus_write(i, 1, 32'h17);
        end
        idle(20);
        check("t6_irq_before", 32'(irq), 1);
        check("t6_pwm_before", 32'(pwm_out), 32'hF);
        #3;
        reset_n = 1'b0;
        #1;
        check("t6_async_irq", 32'(irq), 0);
        check("t6_async_irq_vec", 32'(irq_vec), 0);
        check("t6_async_pwm", 32'(pwm_out), 0);
        check("t6_async_readdata", readdata, 0);
        idle(2);
        reset_n = 1'b1;
        model_reset();
        idle(1);
        for (int i = 0; i < NUM_CH; i++) begin
            for (int j = 0; j < 8; j++) begin
                bus_read(i, j, model_read(i, j), $sformatf("t6_post_rst_ch%0d_r%0d", i, j));
            end
        end
        idle(3);
        check("t6_no_restart", 32'(irq), 0);

        idle(2);
        check("sb_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
